// File: rtl/filter8_pkg.sv
// -----------------------------------------------------------------------------
// filter8_pkg
// Shared types and constants for the Filter8bit datapath.
//   sample_t   : signed sample at the default datapath width
//   WIDTH_DEF  : default sample width
//   DELAY_DEF  : default comb differential delay
//   MAX_DELAY  : deepest delay line a comb stage may be built with
//   sat_sub    : a - b clipped to the sample_t range, with a clip flag.
//                Used by comb_diff8 when COMB_SAT_EN is defined.
// -----------------------------------------------------------------------------
package filter8_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DELAY_DEF = 4;
  localparam int MAX_DELAY = 16;

  typedef logic signed [WIDTH_DEF-1:0] sample_t;

  typedef struct packed {
    sample_t val;
    logic    ovf;
  } sat_t;

  // The difference is formed one bit wider so it cannot wrap. A clip happened
  // exactly when the top two bits of that wide result disagree.
  function automatic sat_t sat_sub(input sample_t a, input sample_t b);
    logic signed [WIDTH_DEF:0] d;
    sat_t                      r;
    d     = {a[WIDTH_DEF-1], a} - {b[WIDTH_DEF-1], b};
    r.ovf = d[WIDTH_DEF] != d[WIDTH_DEF-1];
    if (!r.ovf)
      r.val = d[WIDTH_DEF-1:0];
    else if (d[WIDTH_DEF])
      r.val = {1'b1, {(WIDTH_DEF-1){1'b0}}};
    else
      r.val = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/comb_diff8_if.sv
// -----------------------------------------------------------------------------
// comb_diff8_if
// Sample-in / difference-out valid/ready bus of the comb stage.
//   in_valid, in_ready, in_data      : upstream sample handshake
//   out_valid, out_ready, out_data   : downstream result handshake
//   out_ovf                          : result in out_data was clipped
// Modports: master = the stage's environment (source + sink), slave = the comb.
// -----------------------------------------------------------------------------
interface comb_diff8_if
  import filter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/comb_delay_line.sv
// -----------------------------------------------------------------------------
// comb_delay_line
// Circular buffer holding the last DELAY accepted samples.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush (entries, pointer, fill count)
//   we         : write wdata at the current slot and advance the pointer
//   wdata      : sample being accepted
//   rdata      : the sample written DELAY accepts ago (0 until the line fills)
//   primed     : DELAY samples accepted since the last reset / clear
// rdata is the pre-write contents of the slot about to be overwritten, so a
// read and write of the same slot in one cycle returns the old sample.
// DELAY legal range: 1..MAX_DELAY.
// -----------------------------------------------------------------------------
module comb_delay_line
  import filter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DELAY = DELAY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             primed
);

  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int CW = $clog2(DELAY + 1);

  logic [WIDTH-1:0] line [DELAY];
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    fill;

  assign rdata  = line[wptr];
  assign primed = (fill == CW'(DELAY));

  // NOTE: the entries are reset (not just masked by the fill count) because a
  // cleared line must read back 0 so that y = x until history exists; state
  // registers use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) line[i] <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (clear) begin
      for (int i = 0; i < DELAY; i++) line[i] <= '0;
      wptr <= '0;
      fill <= '0;
    end else if (we) begin
      line[wptr] <= wdata;
      wptr       <= (wptr == PW'(DELAY - 1)) ? '0 : wptr + PW'(1);
      if (!primed) fill <= fill + CW'(1);
    end
  end

endmodule

// File: rtl/comb_diff8.sv
// -----------------------------------------------------------------------------
// comb_diff8
// Streaming comb differencer: y[n] = x[n] - x[n-DELAY], one registered result
// per accepted sample, single skid-free output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush; wins over an accept in the same cycle
//   bus        : comb_diff8_if.slave (in_* sample side, out_* result side)
//   primed     : DELAY samples accepted since the last reset / clear
// Build option COMB_SAT_EN: when defined the difference saturates to the
// signed sample range and out_ovf flags a clipped result (the saturating path
// is sized for the package sample width); when undefined the difference wraps
// modulo 2^WIDTH and out_ovf stays 0.
// -----------------------------------------------------------------------------
module comb_diff8
  import filter8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DELAY = DELAY_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  comb_diff8_if.slave  bus,
  output logic         primed
);

  logic             accept;
  logic [WIDTH-1:0] old;
  logic [WIDTH-1:0] diff_d;
  logic             ovf_d;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             ovf_q;

  // A slot frees up when the held result leaves this cycle; clear blocks the
  // input so the sample presented alongside it is dropped.
  assign bus.in_ready = !clear && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  comb_delay_line #(
    .WIDTH (WIDTH),
    .DELAY (DELAY)
  ) u_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .we     (accept),
    .wdata  (bus.in_data),
    .rdata  (old),
    .primed (primed)
  );

`ifdef COMB_SAT_EN
  sat_t sat_r;

  // NOTE: every always_comb output gets a value on every path, so no latch.
  always_comb begin
    sat_r  = sat_sub(sample_t'(bus.in_data), sample_t'(old));
    diff_d = sat_r.val;
    ovf_d  = sat_r.ovf;
  end
`else
  always_comb begin
    diff_d = bus.in_data - old;
    ovf_d  = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= diff_d;
      ovf_q   <= ovf_d;
    end else if (bus.out_ready) begin
      // Consumed with nothing behind it: data is held, only valid drops.
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_comb_diff8.sv
// -----------------------------------------------------------------------------
// tb_comb_diff8
// Drives three comb_diff8 instances (DELAY = 1, 4, 16) with one shared
// stimulus stream. Expected results come from a history of accepted samples
// and are queued per instance when a sample is accepted, then popped and
// compared when the instance's result is consumed.
// -----------------------------------------------------------------------------
module tb_comb_diff8;

  typedef struct {
    logic [7:0] d;
    logic       o;
  } exp_t;

  localparam int DLYS [3] = '{1, 4, 16};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic [7:0] od [3];
  logic       ov [3];
  logic       oo [3];
  logic       ir [3];
  logic       pr [3];

  int         errors = 0;
  int         checks = 0;
  int         hist [$];
  bit         mvalid;
  exp_t       expq [3][$];
  logic [7:0] cap  [3][$];

  always #5 clk = ~clk;

  comb_diff8_if #(.WIDTH(8)) bus1 ();
  comb_diff8_if #(.WIDTH(8)) bus4 ();
  comb_diff8_if #(.WIDTH(8)) bus16 ();

  assign bus1.in_valid   = in_valid;
  assign bus1.in_data    = in_data;
  assign bus1.out_ready  = out_ready;
  assign bus4.in_valid   = in_valid;
  assign bus4.in_data    = in_data;
  assign bus4.out_ready  = out_ready;
  assign bus16.in_valid  = in_valid;
  assign bus16.in_data   = in_data;
  assign bus16.out_ready = out_ready;

  comb_diff8 #(.WIDTH(8), .DELAY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus1), .primed(pr[0]));
  comb_diff8 #(.WIDTH(8), .DELAY(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus4), .primed(pr[1]));
  comb_diff8 #(.WIDTH(8), .DELAY(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus16), .primed(pr[2]));

  assign od[0] = bus1.out_data;   assign od[1] = bus4.out_data;   assign od[2] = bus16.out_data;
  assign ov[0] = bus1.out_valid;  assign ov[1] = bus4.out_valid;  assign ov[2] = bus16.out_valid;
  assign oo[0] = bus1.out_ovf;    assign oo[1] = bus4.out_ovf;    assign oo[2] = bus16.out_ovf;
  assign ir[0] = bus1.in_ready;   assign ir[1] = bus4.in_ready;   assign ir[2] = bus16.in_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: difference against the sample accepted d accepts earlier,
  // or against 0 while fewer than d samples exist since reset / clear.
  function automatic exp_t model(input int xs, input int d);
    int   old;
    int   diff;
    exp_t e;
    old  = (hist.size() >= d) ? hist[hist.size() - d] : 0;
    diff = xs - old;
`ifdef COMB_SAT_EN
    if (diff > 127) begin
      e.d = 8'h7F; e.o = 1'b1;
    end else if (diff < -128) begin
      e.d = 8'h80; e.o = 1'b1;
    end else begin
      e.d = diff[7:0]; e.o = 1'b0;
    end
`else
    e.d = diff[7:0];
    e.o = 1'b0;
`endif
    return e;
  endfunction

  task automatic model_flush();
    hist.delete();
    mvalid = 1'b0;
    for (int k = 0; k < 3; k++) expq[k].delete();
  endtask

  task automatic cap_flush();
    for (int k = 0; k < 3; k++) cap[k].delete();
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit v, input int x, input bit rdy, input bit clr = 1'b0);
    bit               exp_ready;
    exp_t             e;
    logic signed [7:0] xb;
    int               xs;
    xb        = x[7:0];
    xs        = xb;
    in_valid  = v;
    in_data   = x[7:0];
    out_ready = rdy;
    clear     = clr;
    #1;
    exp_ready = !clr && (!mvalid || rdy);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("in_ready[d%0d]", DLYS[k]), 32'(ir[k]), 32'(exp_ready));
      check($sformatf("out_valid[d%0d]", DLYS[k]), 32'(ov[k]), 32'(mvalid));
      if (mvalid && rdy && !clr) begin
        check($sformatf("pending[d%0d]", DLYS[k]), expq[k].size(), 1);
        if (expq[k].size() > 0) begin
          e = expq[k].pop_front();
          check($sformatf("out_data[d%0d]", DLYS[k]), 32'(od[k]), 32'(e.d));
          check($sformatf("out_ovf[d%0d]", DLYS[k]), 32'(oo[k]), 32'(e.o));
          cap[k].push_back(od[k]);
        end
      end
    end
    if (clr) begin
      model_flush();
    end else begin
      if (mvalid && rdy) mvalid = 1'b0;
      if (v && exp_ready) begin
        for (int k = 0; k < 3; k++) expq[k].push_back(model(xs, DLYS[k]));
        hist.push_back(xs);
        mvalid = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("primed[d%0d]", DLYS[k]), 32'(pr[k]), 32'(hist.size() >= DLYS[k]));
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s out_valid[d%0d]", tag, DLYS[k]), 32'(ov[k]), 32'd0);
      check($sformatf("%s out_data[d%0d]", tag, DLYS[k]), 32'(od[k]), 32'd0);
      check($sformatf("%s out_ovf[d%0d]", tag, DLYS[k]), 32'(oo[k]), 32'd0);
      check($sformatf("%s primed[d%0d]", tag, DLYS[k]), 32'(pr[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] exp_ramp;
    logic [7:0] exp_sat;
    logic       exp_sat_ovf;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    model_flush();
    #3;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, DELAY=4 reference values 10,20,30,40,40,40.
    cap_flush();
    step(1, 10, 1); step(1, 20, 1); step(1, 30, 1);
    check("primed_before_4th", 32'(pr[1]), 32'd0);
    step(1, 40, 1);
    check("primed_at_4th", 32'(pr[1]), 32'd1);
    step(1, 50, 1); step(1, 60, 1); step(0, 0, 1);
    check("stream_count", cap[1].size(), 6);
    if (cap[1].size() == 6) begin
      check("stream_y0", 32'(cap[1][0]), 32'd10);
      check("stream_y3", 32'(cap[1][3]), 32'd40);
      check("stream_y5", 32'(cap[1][5]), 32'd40);
    end

    // Back-pressure: result held 3 cycles, the waiting sample is not lost.
    cap_flush();
    step(1, 5, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 9, 0);
      check("stall_frozen", 32'(od[1]), 32'h0E7);
    end
    step(1, 9, 1);
    step(0, 0, 1);
    check("stall_count", cap[1].size(), 2);
    if (cap[1].size() == 2) check("stall_resume", 32'(cap[1][1]), 32'h0E1);

    // Clear mid-stream with a sample presented: it is dropped.
    step(1, 11, 1);
    cap_flush();
    step(1, 99, 1, 1'b1);
    step(1, 7, 1);
    check("clear_primed4", 32'(pr[1]), 32'd0);
    step(0, 0, 1);
    check("clear_count", cap[1].size(), 1);
    if (cap[1].size() == 1) check("clear_first", 32'(cap[1][0]), 32'd7);

    // Range edge: 100 then -100 through DELAY=1.
`ifdef COMB_SAT_EN
    exp_sat = 8'h80; exp_sat_ovf = 1'b1;
`else
    exp_sat = 8'h38; exp_sat_ovf = 1'b0;
`endif
    step(0, 0, 1, 1'b1);
    step(1, 100, 1);
    check("sat_first", 32'(od[0]), 32'd100);
    step(1, -100, 1);
    check("sat_data", 32'(od[0]), 32'(exp_sat));
    check("sat_ovf", 32'(oo[0]), 32'(exp_sat_ovf));
    step(0, 0, 1);

    // Asynchronous reset while a result is pending.
    step(1, 33, 0);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("async");
    model_flush();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, -5, 1);
    for (int k = 0; k < 3; k++)
      check($sformatf("post_reset[d%0d]", DLYS[k]), 32'(od[k]), 32'h0FB);
    step(0, 0, 1);

    // Ramp of step 1 through DELAY=16: y = x until primed, 16 afterwards.
    step(0, 0, 1, 1'b1);
    cap_flush();
    for (int i = 0; i < 40; i++) step(1, i, 1);
    step(0, 0, 1);
    check("ramp_count", cap[2].size(), 40);
    for (int i = 0; i < 40 && i < cap[2].size(); i += 3) begin
      exp_ramp = (i < 16) ? 8'(i) : 8'd16;
      check($sformatf("ramp_y%0d", i), 32'(cap[2][i]), 32'(exp_ramp));
    end

    // Random traffic with random back-pressure.
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    step(0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
